// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, trap causes,
// responder states and the address-window helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] CAUSE_NONE        = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACCESS   = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACCESS   = 4'd7;

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, RESP} state_t;

  // A byte address below base wraps to a huge offset, so one compare covers both bounds.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input int unsigned addr_w);
    logic [32:0] offset;
    logic [32:0] span;
    offset = {1'b0, addr - base};
    span   = 33'd4 << addr_w;
    return offset < span;
  endfunction

endpackage

// File: rtl/sram_sp.sv
// Single-port synchronous SRAM: one access per cycle, read data registered
// and held until the next read.
module sram_sp #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: validates one request at a time, services it against the
// data SRAM (read-modify-write for sub-word stores) and returns load data or a fault.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [3:0]  rsp_cause
);

  state_t            state, next_state;
  logic              accept;
  logic              acc_legal;
  logic              acc_fault;
  logic [3:0]        acc_cause;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] word_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic              fault_q;
  logic [3:0]        cause_q;

  logic              sram_en;
  logic              sram_we;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  logic [4:0]        lane_shift;
  logic [31:0]       shifted;
  logic [31:0]       load_fmt;
  logic [31:0]       merged;

  assign accept = req_valid && (state == IDLE);

  // Fault priority: illegal funct3, then misalignment, then address window.
  always_comb begin
    acc_cause = CAUSE_NONE;
    if (req_we)
      acc_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    else
      acc_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                  (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    if (!acc_legal)
      acc_cause = CAUSE_ILLEGAL;
    else if (((req_funct3[1:0] == SZ_H) && req_addr[0]) ||
             ((req_funct3[1:0] == SZ_W) && (req_addr[1:0] != 2'b00)))
      acc_cause = req_we ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
    else if (!in_window(req_addr, BASE_ADDR, ADDR_W))
      acc_cause = req_we ? CAUSE_ST_ACCESS : CAUSE_LD_ACCESS;
  end

  assign acc_fault = (acc_cause != CAUSE_NONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (acc_fault)                          next_state = RESP;
          else if (req_we && req_funct3 == F3_W)  next_state = WR;
          else                                    next_state = RD;
        end
      end
      RD:      next_state = we_q ? MRG : RESP;
      MRG:     next_state = WR;
      WR:      next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_fault = 1'b0;
    rsp_cause = CAUSE_NONE;
    rsp_rdata = '0;
    if (state == RESP) begin
      rsp_fault = fault_q;
      rsp_cause = cause_q;
      if (!we_q && !fault_q) rsp_rdata = load_fmt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= F3_B;
      lane_q  <= 2'b00;
      word_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        lane_q  <= req_addr[1:0];
        word_q  <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
        fault_q <= acc_fault;
        cause_q <= acc_cause;
      end
      if (state == MRG) merge_q <= merged;
    end
  end

  // SRAM read data stays put during RESP, so load formatting can be purely combinational.
  always_comb begin
    lane_shift = {lane_q, 3'b000};
    shifted    = sram_rdata >> lane_shift;
    case (f3_q[1:0])
      SZ_B:    load_fmt = f3_q[2] ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    load_fmt = f3_q[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_fmt = sram_rdata;
    endcase
    merged = sram_rdata;
    if (f3_q[1:0] == SZ_B) merged[lane_shift +: 8]            = wdata_q[7:0];
    else                   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  assign sram_we    = (state == WR) && !rst;
  assign sram_en    = (state == RD) || sram_we;
  assign sram_wdata = (f3_q[1:0] == SZ_W) ? wdata_q : merge_q;

  sram_sp #(
    .ADDR_W(ADDR_W),
    .DATA_W(32)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .addr (word_q),
    .wdata(sram_wdata),
    .rdata(sram_rdata)
  );

endmodule
